stop_sequencer: RTL and testbench
=================================

Name: stop_sequencer

Overview:
- Per-round controller that produces the five per-row stop positions (stopX1..stopX5) consumed by the row matcher.
- For each row in turn, it sweeps a marker horizontally, bouncing between two limits and stepping once per frame tick.
- On a player button press it latches the marker X into that row's stop register and advances to the next row.
- After row 5 it signals done so the ball-drop logic can begin.

Parameters:
- XMIN, 80, left sweep limit and marker reset position (pixels)
- XMAX, 560, right sweep limit (pixels)
- STEP, 4, marker displacement per frame tick (pixels); must satisfy 0 < STEP <= XMAX-XMIN

Ports:
- MAX10_CLK1_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous reset, active-low
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse; begins a round
- press  in  1  player button, level, already synchronised, active-high
- busy  out  1  high while sweeping rows 1..5
- done  out  1  high after row 5 latched, until next start
- cur_row  out  3  active row 1..5; 0 when idle or done
- markerX  out  10  current marker X for display
- stopX1..stopX5  out  10 each  latched stop positions per row

Behaviour:
- Reset (reset_n=0 at clock edge):
  - state=IDLE, cur_row=0, markerX=XMIN, dir=right
  - stopX1..5=0, busy=0, done=0, press_q=0
- Reset has priority over every other input and aborts any round in progress.
- Press edge detection:
  - press_q <= press every cycle, in all states including IDLE/DONE.
  - press_rise = press & ~press_q.
  - A button held across start or across a row latch does not latch the next row; release and re-press are required.
- States:
  - IDLE:
    - busy=0, done=0, cur_row=0.
    - start -> SWEEP with cur_row=1, markerX=XMIN, dir=right.
    - press and frame_tick are ignored.
  - SWEEP:
    - busy=1, cur_row=k.
    - frame_tick without press_rise moves the marker:
      - dir=right: if markerX+STEP >= XMAX then markerX=XMAX, dir=left; else markerX += STEP.
      - dir=left: if markerX-STEP <= XMIN (evaluated without underflow, e.g. markerX <= XMIN+STEP) then markerX=XMIN, dir=right; else markerX -= STEP.
    - press_rise latches stopXk <= markerX, using the value before any same-cycle update.
      - Then markerX=XMIN, dir=right.
      - If k<5: cur_row=k+1 and stay in SWEEP.
      - If k=5: -> DONE.
    - press_rise with a simultaneous frame_tick: the latch wins and the tick is dropped.
    - start is ignored.
  - DONE:
    - busy=0, done=1, cur_row=0, markerX=XMIN.
    - stopX1..5 hold their values.
    - start -> SWEEP row 1; done clears on the same edge.
    - Old stopX values persist until each row is re-latched.
- Timing:
  - All outputs are registered.
  - A latched stopXk is visible the cycle after the press_rise edge.
  - cur_row advances on that same edge.
- Arithmetic:
  - 10-bit unsigned.
  - Intermediate sums use 11 bits, so markerX+STEP near 1023 cannot wrap.
- markerX never leaves [XMIN, XMAX].

Test Plan:
- Reset then start; 10 frame_ticks; press rise -> stopX1=120, cur_row=2, markerX=80, busy=1.
- Row 1 with 120 ticks -> markerX=560, dir left. One more tick -> markerX=556. Press -> stopX1=556.
- Press held high through start, then 3 ticks -> no latch, cur_row stays 1. Release, re-press -> stopX1=92.
- Same cycle as tick 5, assert press rise -> stopX1=96 (pre-tick value, after 4 ticks), markerX=80.
- Latch rows 1..5 after 0, 1, 2, 3, 4 ticks:
  - stopX1..5 = 80, 84, 88, 92, 96.
  - done=1, busy=0, cur_row=0.
  - A further press changes nothing.
  - start -> cur_row=1, done=0, stopX values unchanged.
- reset_n low mid-row 3 for one cycle -> all outputs return to reset values next cycle, state IDLE. Later ticks and presses do nothing until start.

Source files
------------

// File: rtl/stop_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stop_sequencer_if
// Purpose  : Frame/start/press inputs and sweep/stop outputs of stop_sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface stop_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       press;
    logic       busy;
    logic       done;
    logic [2:0] cur_row;
    logic [9:0] markerX;
    logic [9:0] stopX1;
    logic [9:0] stopX2;
    logic [9:0] stopX3;
    logic [9:0] stopX4;
    logic [9:0] stopX5;

    modport master (
        output frame_tick, start, press,
        input  busy, done, cur_row, markerX, stopX1, stopX2, stopX3, stopX4, stopX5
    );

    modport slave (
        input  frame_tick, start, press,
        output busy, done, cur_row, markerX, stopX1, stopX2, stopX3, stopX4, stopX5
    );
endinterface
`default_nettype wire

// File: rtl/stop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stop_sequencer
// Purpose  : Sweeps a bouncing marker per row and latches five stop positions.
// Revision : 1.0  initial release
// ============================================================================
module stop_sequencer #(
    parameter int XMIN = 80,
    parameter int XMAX = 560,
    parameter int STEP = 4
) (
    input  wire logic       MAX10_CLK1_50,
    input  wire logic       reset_n,
    stop_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [10:0] C_XMIN_W = 11'(XMIN);
    localparam logic [10:0] C_XMAX_W = 11'(XMAX);
    localparam logic [10:0] C_STEP_W = 11'(STEP);
    localparam logic [9:0]  C_XMIN   = 10'(XMIN);
    localparam logic [9:0]  C_XMAX   = 10'(XMAX);
    localparam logic [9:0]  C_STEP   = 10'(STEP);

    state_t     state_q, state_d;
    logic [2:0] cur_row_q, cur_row_d;
    logic [9:0] marker_q, marker_d;
    logic       dir_left_q, dir_left_d;
    logic [9:0] stop_q [5];
    logic [9:0] stop_d [5];
    logic       press_q, press_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       press_rise;
    logic [10:0] marker_ext;

    always_comb begin
        press_rise = bus.press & ~press_q;
        marker_ext = {1'b0, marker_q};
        press_d    = bus.press;
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        marker_d   = marker_q;
        dir_left_d = dir_left_q;
        for (int i = 0; i < 5; i++) begin
            stop_d[i] = stop_q[i];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_SWEEP;
                    cur_row_d  = 3'd1;
                    marker_d   = C_XMIN;
                    dir_left_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                // A latch takes precedence; a coincident frame tick is dropped.
                if (press_rise) begin
                    for (int i = 0; i < 5; i++) begin
                        if (cur_row_q == 3'(i + 1)) begin
                            stop_d[i] = marker_q;
                        end
                    end
                    marker_d   = C_XMIN;
                    dir_left_d = 1'b0;
                    if (cur_row_q == 3'd5) begin
                        state_d   = ST_DONE;
                        cur_row_d = 3'd0;
                    end else begin
                        cur_row_d = cur_row_q + 3'd1;
                    end
                end else if (bus.frame_tick) begin
                    if (!dir_left_q) begin
                        if (marker_ext + C_STEP_W >= C_XMAX_W) begin
                            marker_d   = C_XMAX;
                            dir_left_d = 1'b1;
                        end else begin
                            marker_d = marker_q + C_STEP;
                        end
                    end else begin
                        if (marker_ext <= C_XMIN_W + C_STEP_W) begin
                            marker_d   = C_XMIN;
                            dir_left_d = 1'b0;
                        end else begin
                            marker_d = marker_q - C_STEP;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cur_row_d = 3'd0;
                marker_d  = C_XMIN;
            end
        endcase

        busy_d = (state_d == ST_SWEEP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_row_q  <= 3'd0;
            marker_q   <= C_XMIN;
            dir_left_q <= 1'b0;
            press_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                stop_q[i] <= 10'd0;
            end
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            marker_q   <= marker_d;
            dir_left_q <= dir_left_d;
            press_q    <= press_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            for (int i = 0; i < 5; i++) begin
                stop_q[i] <= stop_d[i];
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cur_row = cur_row_q;
    assign bus.markerX = marker_q;
    assign bus.stopX1  = stop_q[0];
    assign bus.stopX2  = stop_q[1];
    assign bus.stopX3  = stop_q[2];
    assign bus.stopX4  = stop_q[3];
    assign bus.stopX5  = stop_q[4];
endmodule
`default_nettype wire

// File: tb/tb_stop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stop_sequencer
// Purpose  : Vector table, directed sequences and random run against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stop_sequencer;
    localparam int XMIN = 80;
    localparam int XMAX = 560;
    localparam int STEP = 4;

    logic clk;
    logic reset_n;
    stop_sequencer_if bus ();

    stop_sequencer #(.XMIN(XMIN), .XMAX(XMAX), .STEP(STEP)) dut (
        .MAX10_CLK1_50 (clk),
        .reset_n       (reset_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: 0=idle 1=sweeping 2=done, positions as plain integers.
    int m_phase;
    int m_row;
    int m_pos;
    int m_dir;
    int m_stop [5];
    bit m_prev_press;

    typedef struct {
        bit rn, s, t, p;
        int busy, done, row, marker, s1;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input bit s, input bit t, input bit p);
        bit rise;
        rise = p && !m_prev_press;
        if (!rn) begin
            m_phase = 0; m_row = 0; m_pos = XMIN; m_dir = 1; m_prev_press = 0;
            for (int i = 0; i < 5; i++) m_stop[i] = 0;
            return;
        end
        m_prev_press = p;
        if (m_phase != 1) begin
            if (s) begin
                m_phase = 1; m_row = 1; m_pos = XMIN; m_dir = 1;
            end
        end else if (rise) begin
            m_stop[m_row - 1] = m_pos;
            m_pos = XMIN; m_dir = 1;
            if (m_row == 5) begin
                m_phase = 2; m_row = 0;
            end else begin
                m_row = m_row + 1;
            end
        end else if (t) begin
            m_pos = m_pos + m_dir * STEP;
            if (m_pos >= XMAX) begin
                m_pos = XMAX; m_dir = -1;
            end else if (m_pos <= XMIN) begin
                m_pos = XMIN; m_dir = 1;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit s, input bit t, input bit p);
        reset_n        = rn;
        bus.start      = s;
        bus.frame_tick = t;
        bus.press      = p;
        @(posedge clk);
        model_step(rn, s, t, p);
        #1;
        chk("model_busy",    int'(bus.busy),    (m_phase == 1) ? 1 : 0);
        chk("model_done",    int'(bus.done),    (m_phase == 2) ? 1 : 0);
        chk("model_cur_row", int'(bus.cur_row), m_row);
        chk("model_markerX", int'(bus.markerX), m_pos);
        chk("model_stopX1",  int'(bus.stopX1),  m_stop[0]);
        chk("model_stopX2",  int'(bus.stopX2),  m_stop[1]);
        chk("model_stopX3",  int'(bus.stopX3),  m_stop[2]);
        chk("model_stopX4",  int'(bus.stopX4),  m_stop[3]);
        chk("model_stopX5",  int'(bus.stopX5),  m_stop[4]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},    int'(bus.busy),    0);
        chk({tag, "_done"},    int'(bus.done),    0);
        chk({tag, "_cur_row"}, int'(bus.cur_row), 0);
        chk({tag, "_markerX"}, int'(bus.markerX), 80);
        chk({tag, "_stopX1"},  int'(bus.stopX1),  0);
        chk({tag, "_stopX3"},  int'(bus.stopX3),  0);
    endtask

    initial begin
        bit rp;
        //            rn s t p  busy done row marker s1
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 80, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 0, 0, 80, 0};
        tbl[2]  = '{1, 1, 0, 1, 1, 0, 1, 80, 0};
        tbl[3]  = '{1, 0, 1, 1, 1, 0, 1, 84, 0};
        tbl[4]  = '{1, 0, 1, 0, 1, 0, 1, 88, 0};
        tbl[5]  = '{1, 0, 1, 1, 1, 0, 2, 80, 88};
        tbl[6]  = '{1, 0, 1, 0, 1, 0, 2, 84, 88};
        tbl[7]  = '{1, 0, 0, 1, 1, 0, 3, 80, 88};
        tbl[8]  = '{1, 0, 0, 0, 1, 0, 3, 80, 88};
        tbl[9]  = '{1, 0, 0, 1, 1, 0, 4, 80, 88};
        tbl[10] = '{1, 0, 0, 0, 1, 0, 4, 80, 88};
        tbl[11] = '{1, 0, 0, 1, 1, 0, 5, 80, 88};
        tbl[12] = '{1, 0, 0, 0, 1, 0, 5, 80, 88};
        tbl[13] = '{1, 0, 1, 1, 0, 1, 0, 80, 88};
        tbl[14] = '{1, 0, 1, 0, 0, 1, 0, 80, 88};
        tbl[15] = '{1, 0, 0, 1, 0, 1, 0, 80, 88};
        tbl[16] = '{1, 1, 0, 0, 1, 0, 1, 80, 88};

        reset_n = 1'b0; bus.start = 1'b0; bus.frame_tick = 1'b0; bus.press = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rn, tbl[i].s, tbl[i].t, tbl[i].p);
            chk("tbl_busy",    int'(bus.busy),    tbl[i].busy);
            chk("tbl_done",    int'(bus.done),    tbl[i].done);
            chk("tbl_cur_row", int'(bus.cur_row), tbl[i].row);
            chk("tbl_markerX", int'(bus.markerX), tbl[i].marker);
            chk("tbl_stopX1",  int'(bus.stopX1),  tbl[i].s1);
        end
        chk("tbl_stopX2", int'(bus.stopX2), 84);

        // Ten ticks then press.
        cyc(0, 0, 0, 0);
        chk_reset_vals("rst1");
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("t10_stopX1",  int'(bus.stopX1),  120);
        chk("t10_cur_row", int'(bus.cur_row), 2);
        chk("t10_markerX", int'(bus.markerX), 80);
        chk("t10_busy",    int'(bus.busy),    1);

        // Bounce off the right limit.
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 120; i++) cyc(1, 0, 1, 0);
        chk("bounce_at_max", int'(bus.markerX), 560);
        cyc(1, 0, 1, 0);
        chk("bounce_left", int'(bus.markerX), 556);
        cyc(1, 0, 0, 1);
        chk("bounce_stopX1", int'(bus.stopX1), 556);

        // Press held across start must not latch.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1);
        chk("held_cur_row", int'(bus.cur_row), 1);
        chk("held_stopX1",  int'(bus.stopX1),  0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("repress_stopX1",  int'(bus.stopX1),  92);
        chk("repress_cur_row", int'(bus.cur_row), 2);

        // Press on the same cycle as the fifth tick.
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 1);
        chk("coinc_stopX1",  int'(bus.stopX1),  96);
        chk("coinc_markerX", int'(bus.markerX), 80);

        // Full round: rows latched after 0..4 ticks.
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < r; k++) cyc(1, 0, 1, 0);
            cyc(1, 0, 0, 1);
            cyc(1, 0, 0, 0);
        end
        chk("round_stopX1", int'(bus.stopX1), 80);
        chk("round_stopX2", int'(bus.stopX2), 84);
        chk("round_stopX3", int'(bus.stopX3), 88);
        chk("round_stopX4", int'(bus.stopX4), 92);
        chk("round_stopX5", int'(bus.stopX5), 96);
        chk("round_done",    int'(bus.done),    1);
        chk("round_busy",    int'(bus.busy),    0);
        chk("round_cur_row", int'(bus.cur_row), 0);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 0);
        chk("done_press_stopX1", int'(bus.stopX1), 80);
        chk("done_press_done",   int'(bus.done),   1);
        cyc(1, 1, 0, 0);
        chk("restart_cur_row", int'(bus.cur_row), 1);
        chk("restart_done",    int'(bus.done),    0);
        chk("restart_stopX5",  int'(bus.stopX5),  96);

        // Reset pulse in the middle of row 3.
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk("mid_cur_row", int'(bus.cur_row), 3);
        cyc(0, 0, 0, 0);
        chk_reset_vals("midrst");
        chk("midrst_stopX5", int'(bus.stopX5), 0);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk_reset_vals("post_rst");

        // Randomised run against the model.
        rp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) rp = ~rp;
            cyc(($urandom_range(0, 599) != 0),
                ($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 1)),
                rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
